// File: rtl/sd_img_pkg.sv
// Shared types and constants for the SDRAM-backed sector responder.
package sd_img_pkg;

   typedef enum logic [3:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      RD_PUT,
      WR_ADDR,
      WR_FETCH,
      WR_REQ,
      WR_WAIT,
      DONE
   } state_t;

   localparam int         SECTOR_BYTES = 512;
   localparam logic [7:0] FILL_BYTE    = 8'hFF;

endpackage

// File: rtl/sd_img_server.sv
// Serves 512-byte sector reads/writes to the floppy controller from an image resident in SDRAM.
// First read strobe 2+L cycles after acceptance; every SDRAM access waits for mem_ready.
module sd_img_server
   import sd_img_pkg::*;
#(
   parameter int                ADDR_W   = 23,
   parameter logic [ADDR_W-1:0] IMG_BASE = ADDR_W'(23'h400000)
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              img_en,
   input  logic [13:0]       img_blocks,
   input  logic [31:0]       sd_lba,
   input  logic [1:0]        sd_rd,
   input  logic [1:0]        sd_wr,
   output logic              sd_ack,
   output logic [8:0]        sd_buff_addr,
   output logic [7:0]        sd_buff_dout,
   input  logic [7:0]        sd_buff_din,
   output logic              sd_buff_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [7:0]        mem_din,
   input  logic [7:0]        mem_dout,
   input  logic              mem_ready
);

   state_t      state_q;
   logic        armed_q;
   logic        in_range_q;
   logic [13:0] lba_q;
   logic [9:0]  idx_q;

   logic              req_any_d;
   logic              acc_in_range_d;
   logic              last_d;
   logic [9:0]        idx_inc_d;
   logic [ADDR_W-1:0] addr_next_d;

   function automatic logic [ADDR_W-1:0] byte_addr(input logic [13:0] lba, input logic [8:0] idx);
      return IMG_BASE + ADDR_W'({lba, idx});
   endfunction

   // Drive 0 is the only drive backed by the image; the read vector decides when both ops are requested.
   assign req_any_d      = (|sd_rd) | (|sd_wr);
   assign acc_in_range_d = img_en & ((|sd_rd) ? sd_rd[0] : sd_wr[0])
                           & (sd_lba[31:14] == 18'd0) & (sd_lba[13:0] < img_blocks);
   assign last_d         = (idx_q == 10'(SECTOR_BYTES - 1));
   assign idx_inc_d      = idx_q + 10'd1;
   assign addr_next_d    = byte_addr(lba_q, idx_inc_d[8:0]);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q      <= IDLE;
         armed_q      <= 1'b1;
         in_range_q   <= 1'b0;
         lba_q        <= '0;
         idx_q        <= '0;
         sd_ack       <= 1'b0;
         sd_buff_addr <= '0;
         sd_buff_dout <= '0;
         sd_buff_wr   <= 1'b0;
         mem_addr     <= '0;
         mem_rd       <= 1'b0;
         mem_wr       <= 1'b0;
         mem_din      <= '0;
      end else begin
         sd_buff_wr <= 1'b0;
         if (!req_any_d) armed_q <= 1'b1;

         case (state_q)
            IDLE: begin
               if (armed_q && req_any_d) begin
                  armed_q    <= 1'b0;
                  lba_q      <= sd_lba[13:0];
                  idx_q      <= '0;
                  in_range_q <= acc_in_range_d;
                  sd_ack     <= 1'b1;
                  if (|sd_rd) begin
                     if (acc_in_range_d) begin
                        state_q  <= RD_REQ;
                        mem_rd   <= 1'b1;
                        mem_addr <= byte_addr(sd_lba[13:0], 9'd0);
                     end else begin
                        state_q <= RD_PUT;
                     end
                  end else begin
                     state_q      <= WR_ADDR;
                     sd_buff_addr <= '0;
                  end
               end
            end

            RD_REQ, RD_WAIT: begin
               if (mem_ready) begin
                  mem_rd       <= 1'b0;
                  sd_buff_dout <= mem_dout;
                  sd_buff_addr <= idx_q[8:0];
                  sd_buff_wr   <= 1'b1;
                  state_q      <= RD_PUT;
               end else begin
                  state_q <= RD_WAIT;
               end
            end

            // Entered with the strobe low only on the fill path, which spends one extra cycle per byte.
            RD_PUT: begin
               if (!sd_buff_wr) begin
                  sd_buff_wr   <= 1'b1;
                  sd_buff_addr <= idx_q[8:0];
                  sd_buff_dout <= FILL_BYTE;
               end else begin
                  idx_q <= idx_inc_d;
                  if (last_d) begin
                     state_q <= DONE;
                     sd_ack  <= 1'b0;
                  end else if (in_range_q) begin
                     state_q  <= RD_REQ;
                     mem_rd   <= 1'b1;
                     mem_addr <= addr_next_d;
                  end
               end
            end

            WR_ADDR: state_q <= WR_FETCH;

            WR_FETCH: begin
               if (in_range_q) begin
                  mem_din  <= sd_buff_din;
                  mem_wr   <= 1'b1;
                  mem_addr <= byte_addr(lba_q, idx_q[8:0]);
                  state_q  <= WR_REQ;
               end else begin
                  idx_q <= idx_inc_d;
                  if (last_d) begin
                     state_q <= DONE;
                     sd_ack  <= 1'b0;
                  end else begin
                     state_q      <= WR_ADDR;
                     sd_buff_addr <= idx_inc_d[8:0];
                  end
               end
            end

            WR_REQ, WR_WAIT: begin
               if (mem_ready) begin
                  mem_wr <= 1'b0;
                  idx_q  <= idx_inc_d;
                  if (last_d) begin
                     state_q <= DONE;
                     sd_ack  <= 1'b0;
                  end else begin
                     state_q      <= WR_ADDR;
                     sd_buff_addr <= idx_inc_d[8:0];
                  end
               end else begin
                  state_q <= WR_WAIT;
               end
            end

            DONE: state_q <= IDLE;

            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_img_server.sv
// Randomised scoreboard bench for sd_img_server with behavioural SDRAM and sector-buffer models.
module tb_sd_img_server;

   localparam logic [22:0] IMG_BASE = 23'h400000;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        img_en = 1'b0;
   logic [13:0] img_blocks = '0;
   logic [31:0] sd_lba = '0;
   logic [1:0]  sd_rd = '0;
   logic [1:0]  sd_wr = '0;
   logic        sd_ack;
   logic [8:0]  sd_buff_addr;
   logic [7:0]  sd_buff_dout;
   logic [7:0]  sd_buff_din = '0;
   logic        sd_buff_wr;
   logic [22:0] mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout = '0;
   logic        mem_ready = 1'b0;

   sd_img_server #(.ADDR_W(23), .IMG_BASE(IMG_BASE)) dut (
      .clk_sys(clk_sys), .reset(reset), .img_en(img_en), .img_blocks(img_blocks),
      .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
      .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_din(sd_buff_din),
      .sd_buff_wr(sd_buff_wr), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_ready(mem_ready)
   );

   always #5 clk_sys = ~clk_sys;

   int cyc = 0;
   always @(posedge clk_sys) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic [16:0] exp_put[$];   // {buffer index, byte}
   logic [30:0] exp_mw[$];    // {SDRAM address, byte}
   logic [7:0]  wbuf[512];

   int          n_put = 0, n_rd_rise = 0, n_wr_rise = 0, n_both = 0, n_ack_rise = 0;
   int          rd_rise_xfer = 0;
   logic [22:0] first_rd_addr = '0;
   int          first_ready_cyc = 0, first_put_cyc = 0;
   bit          seen_ready = 0, seen_put = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // SDRAM model: contents are addr[7:0]^5A; completion after 1..3 cycles of a held request.
   initial begin
      int   age;
      int   lat;
      logic prd, pwr;
      logic [30:0] e;
      age = 0; lat = 3; prd = 0; pwr = 0;
      forever begin
         @(negedge clk_sys);
         if (mem_rd && mem_wr) n_both++;
         if (mem_rd && !prd) begin
            if (rd_rise_xfer == 0) first_rd_addr = mem_addr;
            rd_rise_xfer++;
            n_rd_rise++;
         end
         if (mem_wr && !pwr) n_wr_rise++;
         prd = mem_rd;
         pwr = mem_wr;
         if (mem_ready) begin
            mem_ready = 1'b0;
         end else if (reset || !(mem_rd || mem_wr)) begin
            age = 0;
         end else begin
            age++;
            if (age >= lat) begin
               mem_ready = 1'b1;
               age = 0;
               lat = $urandom_range(1, 3);
               if (mem_rd) begin
                  mem_dout = mem_addr[7:0] ^ 8'h5A;
                  if (!seen_ready) begin
                     seen_ready = 1;
                     first_ready_cyc = cyc;
                  end
               end else begin
                  check("mem_wr expected", exp_mw.size() != 0, 1);
                  if (exp_mw.size() != 0) begin
                     e = exp_mw.pop_front();
                     check("mem_wr addr", mem_addr, e[30:8]);
                     check("mem_wr data", mem_din, e[7:0]);
                  end
               end
            end
         end
      end
   end

   // Initiator buffer: data for an address appears one cycle after the address is presented.
   initial begin
      logic [8:0] prev;
      prev = '0;
      forever begin
         @(negedge clk_sys);
         sd_buff_din = wbuf[prev];
         prev = sd_buff_addr;
      end
   end

   // Monitor: every buffer strobe is matched against the scoreboard.
   initial begin
      logic        pack;
      logic [16:0] e;
      pack = 0;
      forever begin
         @(negedge clk_sys);
         if (sd_ack && !pack) n_ack_rise++;
         pack = sd_ack;
         if (sd_buff_wr) begin
            n_put++;
            if (!seen_put) begin
               seen_put = 1;
               first_put_cyc = cyc;
            end
            check("strobe inside ack", sd_ack, 1);
            check("strobe expected", exp_put.size() != 0, 1);
            if (exp_put.size() != 0) begin
               e = exp_put.pop_front();
               check("buff addr", sd_buff_addr, e[16:8]);
               check("buff data", sd_buff_dout, e[7:0]);
            end
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, " sd_ack"}, sd_ack, 0);
      check({tag, " sd_buff_wr"}, sd_buff_wr, 0);
      check({tag, " sd_buff_addr"}, sd_buff_addr, 0);
      check({tag, " sd_buff_dout"}, sd_buff_dout, 0);
      check({tag, " mem_rd"}, mem_rd, 0);
      check({tag, " mem_wr"}, mem_wr, 0);
      check({tag, " mem_addr"}, mem_addr, 0);
      check({tag, " mem_din"}, mem_din, 0);
   endtask

   function automatic logic [22:0] img_addr(input logic [31:0] lba, input int i);
      logic [63:0] full;
      full = 64'(IMG_BASE) + 64'(lba) * 64'd512 + 64'(i);
      return full[22:0];
   endfunction

   // One complete transfer, expectations derived from the request and image state at issue time.
   task automatic xfer(input logic [1:0] rdv, input logic [1:0] wrv, input logic [31:0] lba,
                       input bit hold, input bit wiggle, input bit pattern);
      bit          is_rd, inr;
      logic [1:0]  v;
      logic [22:0] a;
      logic [13:0] save_blocks;
      logic        save_en;
      int          p0, r0, w0, acc, k, ack0;
      is_rd = |rdv;
      v     = is_rd ? rdv : wrv;
      inr   = img_en && v[0] && (lba < 32'(img_blocks));
      for (int i = 0; i < 512; i++) begin
         a = img_addr(lba, i);
         if (is_rd) begin
            exp_put.push_back({i[8:0], inr ? (a[7:0] ^ 8'h5A) : 8'hFF});
         end else begin
            wbuf[i] = pattern ? i[7:0] : 8'($urandom);
            if (inr) exp_mw.push_back({a, wbuf[i]});
         end
      end
      p0 = n_put; r0 = n_rd_rise; w0 = n_wr_rise;
      rd_rise_xfer = 0; seen_ready = 0; seen_put = 0;
      save_blocks = img_blocks; save_en = img_en;
      @(negedge clk_sys);
      sd_lba = lba; sd_rd = rdv; sd_wr = wrv;
      acc = cyc;
      @(negedge clk_sys);
      check("sd_ack rises after acceptance", sd_ack, 1);
      if (wiggle) begin
         img_en = ~img_en;
         img_blocks = ~img_blocks;
      end
      if (!hold) begin
         sd_rd = 2'b00; sd_wr = 2'b00;
      end
      k = 0;
      while (sd_ack && k < 6000) begin
         @(negedge clk_sys);
         k++;
      end
      check("sd_ack falls at end", sd_ack, 0);
      img_en = save_en; img_blocks = save_blocks;
      check("strobes left over", exp_put.size(), 0);
      check("writes left over", exp_mw.size(), 0);
      check("strobe count", n_put - p0, is_rd ? 512 : 0);
      check("mem_rd count", n_rd_rise - r0, (is_rd && inr) ? 512 : 0);
      check("mem_wr count", n_wr_rise - w0, (!is_rd && inr) ? 512 : 0);
      if (is_rd && inr) begin
         check("first mem_addr", first_rd_addr, img_addr(lba, 0));
         check("first strobe latency", first_put_cyc - acc, 2 + (first_ready_cyc - (acc + 1)));
      end
      if (hold) begin
         ack0 = n_ack_rise;
         repeat (10) @(negedge clk_sys);
         check("held request not re-served", n_ack_rise - ack0, 0);
      end
      @(negedge clk_sys);
      sd_rd = 2'b00; sd_wr = 2'b00;
   endtask

   task automatic reset_mid_read(input logic [31:0] lba);
      int p0, k;
      for (int i = 0; i < 512; i++) begin
         exp_put.push_back({i[8:0], img_addr(lba, i)[7:0] ^ 8'h5A});
      end
      p0 = n_put;
      @(negedge clk_sys);
      sd_lba = lba; sd_rd = 2'b01;
      k = 0;
      while ((n_put - p0) < 200 && k < 4000) begin
         @(negedge clk_sys);
         k++;
      end
      check("reached byte 200", (n_put - p0) >= 200, 1);
      reset = 1'b1;
      sd_rd = 2'b00;
      @(negedge clk_sys);
      check_all_zero("after mid reset");
      reset = 1'b0;
      exp_put.delete();
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [1:0]  rv, wv;
      logic [31:0] lba;
      repeat (3) @(negedge clk_sys);
      check_all_zero("reset");
      reset = 1'b0;
      img_en = 1'b1;
      img_blocks = 14'd360;

      xfer(2'b01, 2'b00, 32'd3,   0, 0, 0);
      xfer(2'b00, 2'b01, 32'd0,   0, 0, 1);
      xfer(2'b01, 2'b00, 32'd360, 0, 0, 0);
      xfer(2'b10, 2'b00, 32'd5,   0, 0, 0);
      xfer(2'b00, 2'b01, 32'd360, 0, 0, 0);
      xfer(2'b00, 2'b10, 32'd5,   0, 0, 0);
      img_en = 1'b0;
      xfer(2'b01, 2'b00, 32'd5,   0, 0, 0);
      xfer(2'b00, 2'b01, 32'd5,   0, 0, 0);
      img_en = 1'b1;
      xfer(2'b01, 2'b01, 32'd7,   1, 0, 0);
      reset_mid_read(32'd20);
      xfer(2'b01, 2'b00, 32'd9,   0, 0, 0);
      xfer(2'b01, 2'b00, 32'd5,   0, 0, 0);
      xfer(2'b01, 2'b00, 32'd6,   1, 0, 0);

      for (int t = 0; t < 8; t++) begin
         img_blocks = 14'($urandom_range(1, 16383));
         img_en = ($urandom_range(0, 5) != 0);
         case ($urandom_range(0, 3))
            0: lba = 32'($urandom_range(0, int'(img_blocks) - 1));
            1: lba = 32'(img_blocks) + 32'($urandom_range(0, 3));
            2: lba = $urandom;
            default: lba = 32'(img_blocks) - 32'd1;
         endcase
         rv = 2'($urandom_range(0, 3));
         wv = 2'($urandom_range(0, 3));
         if (rv == 2'b00 && wv == 2'b00) rv = 2'b01;
         xfer(rv, wv, lba, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      end

      check("mem_rd and mem_wr overlap", n_both, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
